// File: rtl/jtdd_objdma_if.sv
// ---------------------------------------------------------------------------
// jtdd_objdma_if
// Bus bundle between the object-RAM DMA sequencer and its surroundings: the
// CPU bus handshake, the work-RAM read port and the object line-buffer write
// port.
//   bus_req   DMA -> CPU     request the CPU bus
//   bus_ack   CPU -> DMA     CPU has released the bus
//   blcnten   DMA -> RAM mux 1 = RAM address comes from obj_AB
//   obj_AB    DMA -> RAM     read address inside the object window
//   ram_dout  RAM -> DMA     read data, one cen tick behind obj_AB
//   buf_addr  DMA -> buffer  line-buffer write address
//   buf_data  DMA -> buffer  line-buffer write data
//   buf_we    DMA -> buffer  line-buffer write strobe
// Modports: master = DMA side, slave = CPU/RAM/buffer side.
// ---------------------------------------------------------------------------
interface jtdd_objdma_if #(
    parameter int AW = 9
);
    logic          bus_req;
    logic          bus_ack;
    logic          blcnten;
    logic [AW-1:0] obj_AB;
    logic [7:0]    ram_dout;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          buf_we;

    modport master (
        output bus_req, blcnten, obj_AB, buf_addr, buf_data, buf_we,
        input  bus_ack, ram_dout
    );

    modport slave (
        input  bus_req, blcnten, obj_AB, buf_addr, buf_data, buf_we,
        output bus_ack, ram_dout
    );
endinterface

// File: rtl/jtdd_objdma.sv
// ---------------------------------------------------------------------------
// jtdd_objdma
// Copies the object table from the shared CPU work RAM into the object line
// buffer once per frame. At the start of vertical blank it requests the CPU
// bus, takes over the RAM address mux once the CPU acknowledges, streams LEN
// bytes and hands the bus back.
// Ports:
//   clk      system clock
//   rst_n    asynchronous reset, active low
//   cen      clock enable shared with the work RAM; all state moves on it
//   enable   1 = arm a copy on the next blanking start
//   LVBL     vertical blank, low while blanking
//   bus      jtdd_objdma_if master: bus handshake, RAM read, buffer write
//   busy     transfer in progress (request through release)
//   done     one-tick pulse when a full copy has been written
//   abort    one-tick pulse on request timeout or lost bus acknowledge
// ---------------------------------------------------------------------------
module jtdd_objdma #(
    parameter int AW      = 9,
    parameter int LEN     = 512,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic                 enable,
    input  logic                 LVBL,
    jtdd_objdma_if.master        bus,
    output logic                 busy,
    output logic                 done,
    output logic                 abort
);
    localparam logic [AW-1:0] LAST     = AW'(LEN - 1);
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COPY,
        FLUSH,
        REL
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    cnt_reg, cnt_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          last_lvbl_reg;

    logic          start;
    logic          we;
    logic [AW-1:0] wa;
    logic [7:0]    wd;
    logic          done_c;
    logic          abort_c;

    // Falling edge of LVBL as seen on cen ticks
    assign start = last_lvbl_reg && !LVBL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            last_lvbl_reg <= 1'b1;
        end else if (cen) begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            last_lvbl_reg <= LVBL;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        we         = 1'b0;
        wa         = '0;
        wd         = '0;
        done_c     = 1'b0;
        abort_c    = 1'b0;
        if (cen) begin
            case (state_reg)
                IDLE: begin
                    cnt_next = '0;
                    if (start && enable) begin
                        state_next = REQ;
                    end
                end
                REQ: begin
                    if (bus.bus_ack) begin
                        state_next = COPY;
                        addr_next  = '0;
                        cnt_next   = '0;
                    end else if (cnt_reg == TMO_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                        abort_c    = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
                COPY: begin
                    if (!bus.bus_ack) begin
                        state_next = REL;
                        abort_c    = 1'b1;
                    end else begin
                        // RAM data trails the address by one tick, so the
                        // very first tick (address 0 just issued) has
                        // nothing to write yet.
                        if (addr_reg != '0) begin
                            we = 1'b1;
                            wa = addr_reg - 1'b1;
                            wd = bus.ram_dout;
                        end
                        if (addr_reg == LAST) begin
                            state_next = FLUSH;
                        end else begin
                            addr_next = addr_reg + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Drain the byte still in flight from the last address
                    if (!bus.bus_ack) begin
                        state_next = REL;
                        abort_c    = 1'b1;
                    end else begin
                        we         = 1'b1;
                        wa         = LAST;
                        wd         = bus.ram_dout;
                        done_c     = 1'b1;
                        state_next = REL;
                    end
                end
                REL: begin
                    if (!bus.bus_ack) begin
                        state_next = IDLE;
                        addr_next  = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.bus_req  = (state_reg == REQ) || (state_reg == COPY) || (state_reg == FLUSH);
    assign bus.blcnten  = (state_reg == COPY) || (state_reg == FLUSH);
    assign bus.obj_AB   = addr_reg;
    assign bus.buf_we   = we;
    assign bus.buf_addr = wa;
    assign bus.buf_data = wd;
    assign busy         = (state_reg != IDLE);
    assign done         = done_c;
    assign abort        = abort_c;
endmodule

// File: tb/tb_jtdd_objdma.sv
// ---------------------------------------------------------------------------
// tb_jtdd_objdma
// Self-checking bench for jtdd_objdma. A CPU model grants the bus a chosen
// number of ticks after the request, a RAM model answers reads one cen tick
// late, and the object buffer writes are captured. Each frame's expected
// byte count, timing and buffer contents follow from the copy rules.
// ---------------------------------------------------------------------------
module tb_jtdd_objdma;
    localparam int AW      = 9;
    localparam int LEN     = 512;
    localparam int TIMEOUT = 255;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic cen    = 1'b0;
    logic enable = 1'b0;
    logic LVBL   = 1'b1;
    logic busy, done, abort;

    jtdd_objdma_if #(.AW(AW)) bus ();

    jtdd_objdma #(
        .AW      (AW),
        .LEN     (LEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .enable (enable),
        .LVBL   (LVBL),
        .bus    (bus),
        .busy   (busy),
        .done   (done),
        .abort  (abort)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram  [LEN];
    logic [7:0] obuf [LEN];

    int tick, n_we, n_bl, n_done, n_abort, n_req, n_stray;
    int first_we, last_we, last_we_addr, done_tick, abort_tick, ack_tick, start_tick;
    int req_seen, ack_delay, drop_at, refall_at, rst_at, lvbl_timer, rst_hold;
    bit dropped, refall_done, rst_done, saw_busy;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int buf_errs(input int nexp);
        int e = 0;
        for (int i = 0; i < nexp; i++) begin
            if (obuf[i] !== ram[i]) e++;
        end
        return e;
    endfunction

    // One clk cycle, entered and left at posedge+1
    task automatic step();
        logic [AW-1:0] a;
        if (cen) begin
            tick++;
            if (refall_at >= 0 && !refall_done && bus.blcnten && int'(bus.obj_AB) == refall_at) begin
                lvbl_timer  = 5;
                enable      = 1'b0;
                refall_done = 1'b1;
            end
            LVBL = (lvbl_timer > 0) ? 1'b0 : 1'b1;
            if (lvbl_timer > 0) lvbl_timer--;
            if (!LVBL && start_tick < 0) start_tick = tick;
            if (drop_at >= 0 && bus.blcnten && int'(bus.obj_AB) == drop_at) dropped = 1'b1;
            if (bus.bus_req) req_seen++;
            bus.bus_ack = (bus.bus_req && ack_delay > 0 && req_seen >= ack_delay && !dropped) ? 1'b1 : 1'b0;
            if (bus.bus_ack && ack_tick < 0) ack_tick = tick;
        end
        #1;
        if (cen) begin
            if (bus.bus_req) n_req++;
            if (bus.blcnten) n_bl++;
            if (busy) saw_busy = 1'b1;
            if (done) begin n_done++; done_tick = tick; end
            if (abort) begin n_abort++; abort_tick = tick; end
            if (bus.buf_we) begin
                n_we++;
                obuf[bus.buf_addr] = bus.buf_data;
                if (first_we < 0) first_we = tick;
                last_we      = tick;
                last_we_addr = int'(bus.buf_addr);
            end
        end else if (bus.buf_we || done || abort) begin
            n_stray++;
        end
        if (rst_at >= 0 && !rst_done && bus.blcnten && int'(bus.obj_AB) == rst_at) begin
            rst_done = 1'b1;
            #1 rst_n = 1'b0;
            #1;
            check("async_rst_outputs",
                  {bus.bus_req, bus.blcnten, bus.obj_AB, bus.buf_addr, bus.buf_data,
                   bus.buf_we, busy, done, abort}, 0);
            rst_hold = 3;
        end else if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst_n = 1'b1;
        end
        a = bus.obj_AB;
        @(posedge clk);
        #1;
        if (cen) bus.ram_dout = ram[a];
        cen = ~cen;
    endtask

    task automatic frame(input string name, input bit en, input int ackd, input int drop,
                         input int refall, input int rstat, input int max_steps);
        int tail_req;
        for (int i = 0; i < LEN; i++) begin
            ram[i]  = 8'($urandom);
            obuf[i] = ~ram[i];
        end
        tick = 0; n_we = 0; n_bl = 0; n_done = 0; n_abort = 0; n_req = 0; n_stray = 0;
        first_we = -1; last_we = -1; last_we_addr = -1; done_tick = -1; abort_tick = -1;
        ack_tick = -1; start_tick = -1; req_seen = 0; rst_hold = 0;
        ack_delay = ackd; drop_at = drop; refall_at = refall; rst_at = rstat;
        dropped = 1'b0; refall_done = 1'b0; rst_done = 1'b0; saw_busy = 1'b0;
        enable = en;
        lvbl_timer = 10;
        for (int i = 0; i < max_steps; i++) begin
            step();
            if (saw_busy && !busy && rst_hold == 0 && rst_n) break;
        end
        check({name, ":idle_at_end"}, busy, 0);
        tail_req = n_req;
        repeat (40) step();
        check({name, ":no_restart"}, n_req - tail_req, 0);
        $display("frame %s: start@%0d ack@%0d writes=%0d blcnten=%0d done=%0d abort=%0d",
                 name, start_tick, ack_tick, n_we, n_bl, n_done, n_abort);
    endtask

    task automatic check_full(input string name);
        check({name, ":writes"},    n_we, LEN);
        check({name, ":buf_errs"},  buf_errs(LEN), 0);
        check({name, ":first_we"},  first_we, ack_tick + 2);
        check({name, ":last_we"},   last_we, ack_tick + LEN + 1);
        check({name, ":blcnten"},   n_bl, LEN + 1);
        check({name, ":done_cnt"},  n_done, 1);
        check({name, ":done_tick"}, done_tick, ack_tick + LEN + 1);
        check({name, ":abort_cnt"}, n_abort, 0);
        check({name, ":stray"},     n_stray, 0);
    endtask

    task automatic check_drop(input string name, input int d);
        check({name, ":writes"},     n_we, d - 1);
        check({name, ":last_addr"},  last_we_addr, d - 2);
        check({name, ":buf_errs"},   buf_errs(d - 1), 0);
        check({name, ":blcnten"},    n_bl, d + 1);
        check({name, ":abort_cnt"},  n_abort, 1);
        check({name, ":abort_tick"}, abort_tick, ack_tick + d + 1);
        check({name, ":done_cnt"},   n_done, 0);
        check({name, ":stray"},      n_stray, 0);
    endtask

    initial begin
        int d;
        bus.bus_ack  = 1'b0;
        bus.ram_dout = 8'h00;
        ack_delay = 0; drop_at = -1; refall_at = -1; rst_at = -1; lvbl_timer = 0; rst_hold = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {bus.bus_req, bus.blcnten, bus.obj_AB, bus.buf_addr, bus.buf_data,
               bus.buf_we, busy, done, abort}, 0);
        rst_n = 1'b1;
        repeat (4) step();

        // Full copy, ack on the third request tick
        frame("full_ack3", 1'b1, 3, -1, -1, -1, 3000);
        check_full("full_ack3");

        // Full copies with random grant latency
        for (int k = 0; k < 2; k++) begin
            frame("full_rand", 1'b1, int'($urandom_range(1, 8)), -1, -1, -1, 3000);
            check_full("full_rand");
        end

        // Disarmed: blanking start must not request the bus
        frame("disabled", 1'b0, 3, -1, -1, -1, 1400);
        check("disabled:req_ticks", n_req, 0);
        check("disabled:writes",    n_we, 0);
        check("disabled:blcnten",   n_bl, 0);

        // No grant: give up after TIMEOUT request ticks
        frame("timeout", 1'b1, 0, -1, -1, -1, 3000);
        check("timeout:req_ticks",  n_req, TIMEOUT);
        check("timeout:abort_cnt",  n_abort, 1);
        check("timeout:abort_tick", abort_tick, start_tick + TIMEOUT);
        check("timeout:writes",     n_we, 0);
        check("timeout:done_cnt",   n_done, 0);

        // Grant withdrawn mid-copy
        frame("drop100", 1'b1, 3, 100, -1, -1, 3000);
        check_drop("drop100", 100);
        d = int'($urandom_range(2, LEN - 3));
        frame("drop_rand", 1'b1, int'($urandom_range(1, 8)), d, -1, -1, 3000);
        check_drop("drop_rand", d);

        // Second blanking start and disarm during copy: copy still completes once
        frame("refall", 1'b1, 2, -1, 300, -1, 3000);
        check_full("refall");

        // Asynchronous reset mid-copy, then a normal frame
        frame("reset200", 1'b1, 2, -1, -1, 200, 3000);
        check("reset200:done_cnt",  n_done, 0);
        check("reset200:abort_cnt", n_abort, 0);
        frame("after_reset", 1'b1, 4, -1, -1, -1, 3000);
        check_full("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
